// File: rtl/mem_pkg.sv
// Shared types for the load/store path: access sizes and the LSU sequencing states.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam logic [3:0] MASK_SH = 4'b0011;
  localparam logic [3:0] MASK_SW = 4'b1111;

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word lane of a memory word and extends it to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = word >> {offset, 3'b000};

  // Pick the lane width and fill the upper bits with zeros or the lane's sign bit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    result = shifted;
    case (size)
      BYTE:    result = {{24{sign & shifted[7]}},  shifted[7:0]};
      HALF:    result = {{16{sign & shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a one-cycle-latency BRAM.
// Store: accept N, write N+1, respond N+2. Load: accept N, read N+1, capture N+2, respond N+3.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              MemRead,
  input  logic [3:0]        MemWrite,
  input  logic [1:0]        MemReadSize,
  input  logic              MemReadSigned,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              misaligned,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t  state, state_nxt;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        read_q;
  logic [3:0]  we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        mis_q;
  logic [31:0] rword_q;

  logic        req_live;
  logic        accept;
  logic        mis_now;
  logic [3:0]  we_lane;
  logic [31:0] ext_data;

  // A request with neither read nor write is not a request at all.
  assign req_live = MemRead | (|MemWrite);
  assign accept   = req_valid & req_live & (state == IDLE);

  // Rejection decided at acceptance time from the raw request.
  assign mis_now = (MemRead & (|MemWrite))
                 | (MemRead & (MemReadSize == 2'd3))
                 | (addr[0] & ((MemRead & (MemReadSize == HALF)) | (MemWrite == MASK_SH)))
                 | ((|addr[1:0]) & ((MemRead & (MemReadSize == WORD)) | (MemWrite == MASK_SW)));

  assign we_lane   = we_q << addr_q[1:0];
  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign mem_wdata = wdata_q << {addr_q[1:0], 3'b000};

  load_extend u_load_extend (
    .word   (rword_q),
    .offset (addr_q[1:0]),
    .size   (mem_size_t'(size_q)),
    .sign   (signed_q),
    .result (ext_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request capture on acceptance and load-word capture one cycle after the BRAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      read_q   <= 1'b0;
      we_q     <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      mis_q    <= 1'b0;
      rword_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= addr;
        wdata_q  <= wdata;
        read_q   <= MemRead;
        we_q     <= MemWrite;
        size_q   <= MemReadSize;
        signed_q <= MemReadSigned;
        mis_q    <= mis_now;
      end
      if (state == WAIT) rword_q <= mem_rdata;
    end
  end

  // Next-state and per-state memory/response outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 4'b0000;
    resp_valid = 1'b0;
    misaligned = 1'b0;
    rdata      = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && req_live) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (mis_q) begin
          state_nxt = RESP;
        end else if (read_q) begin
          mem_en    = 1'b1;
          state_nxt = WAIT;
        end else begin
          mem_en    = 1'b1;
          mem_we    = we_lane;
          state_nxt = RESP;
        end
      end
      WAIT: state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        misaligned = mis_q;
        if (read_q && !mis_q) rdata = ext_data;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency byte-writable BRAM model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemRead;
  logic [3:0]  MemWrite;
  logic [1:0]  MemReadSize;
  logic        MemReadSigned;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misaligned;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] bram [256];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(30)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .addr          (addr),
    .wdata         (wdata),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemReadSize   (MemReadSize),
    .MemReadSigned (MemReadSigned),
    .resp_valid    (resp_valid),
    .rdata         (rdata),
    .misaligned    (misaligned),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // Synchronous BRAM: byte-lane writes, read data one cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) bram[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= bram[mem_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid     = 1'b0;
    addr          = '0;
    wdata         = '0;
    MemRead       = 1'b0;
    MemWrite      = 4'b0000;
    MemReadSize   = 2'd0;
    MemReadSigned = 1'b0;
  endtask

  // Issue one request and check every phase of it against hand-computed values.
  task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic rd, input logic [3:0] we, input logic [1:0] sz,
                         input logic sg, input logic exp_mis, input logic [3:0] exp_we,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    addr = a; wdata = wd; MemRead = rd; MemWrite = we;
    MemReadSize = sz; MemReadSigned = sg; req_valid = 1'b1;
    step();
    idle_inputs();
    check({tag, ":issue_ready"}, {31'd0, req_ready}, 32'd0);
    check({tag, ":issue_en"}, {31'd0, mem_en}, {31'd0, !exp_mis});
    check({tag, ":issue_we"}, {28'd0, mem_we}, {28'd0, exp_we});
    if (!exp_mis) check({tag, ":issue_addr"}, {2'b00, mem_addr}, {2'b00, a[31:2]});
    if (!exp_mis && we != 4'b0000) check({tag, ":issue_wdata"}, mem_wdata, exp_wdata);
    if (rd && !exp_mis) begin
      step();
      check({tag, ":wait_valid"}, {31'd0, resp_valid}, 32'd0);
      check({tag, ":wait_en"}, {31'd0, mem_en}, 32'd0);
    end
    step();
    check({tag, ":resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, ":resp_mis"}, {31'd0, misaligned}, {31'd0, exp_mis});
    check({tag, ":resp_rdata"}, rdata, exp_rdata);
    check({tag, ":resp_en"}, {31'd0, mem_en}, 32'd0);
    step();
    check({tag, ":after_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, ":after_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bram[i] = '0;
    mem_rdata = '0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst:ready", {31'd0, req_ready}, 32'd1);
    check("rst:valid", {31'd0, resp_valid}, 32'd0);
    check("rst:mis", {31'd0, misaligned}, 32'd0);
    check("rst:en", {31'd0, mem_en}, 32'd0);
    check("rst:we", {28'd0, mem_we}, 32'd0);
    check("rst:rdata", rdata, 32'd0);
    rst = 1'b0;
    step();

    //      tag      addr          wdata         rd    we       sz    sg    mis   exp_we   exp_wdata     exp_rdata
    run_req("sw",    32'h100, 32'hDEADBEEF, 1'b0, 4'b1111, 2'd0, 1'b0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);
    run_req("sb",    32'h103, 32'h000000AB, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0, 4'b1000, 32'hAB000000, 32'h0);
    run_req("lw100", 32'h100, 32'h0,        1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hABADBEEF);
    run_req("sw200", 32'h200, 32'h80FF7F01, 1'b0, 4'b1111, 2'd0, 1'b0, 1'b0, 4'b1111, 32'h80FF7F01, 32'h0);
    run_req("lb",    32'h202, 32'h0,        1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'hFFFFFFFF);
    run_req("lbu",   32'h202, 32'h0,        1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h000000FF);
    run_req("lh",    32'h202, 32'h0,        1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 4'b0000, 32'h0,        32'hFFFF80FF);
    run_req("lhu",   32'h202, 32'h0,        1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h000080FF);
    run_req("lb1",   32'h201, 32'h0,        1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0000007F);
    run_req("lws",   32'h200, 32'h0,        1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h80FF7F01);
    run_req("sh",    32'h102, 32'h00001234, 1'b0, 4'b0011, 2'd0, 1'b0, 1'b0, 4'b1100, 32'h12340000, 32'h0);
    run_req("lh102", 32'h102, 32'h0,        1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h00001234);
    run_req("lw_mis",32'h201, 32'h0,        1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0);
    run_req("sh_mis",32'h101, 32'h5555,     1'b0, 4'b0011, 2'd0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0);
    run_req("sz3",   32'h200, 32'h0,        1'b1, 4'b0000, 2'd3, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0);
    run_req("rdwr",  32'h200, 32'h0,        1'b1, 4'b1111, 2'd2, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0);
    run_req("lh_unch",32'h102,32'h0,        1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h00001234);

    // A request with no read and no write is ignored.
    addr = 32'h300; MemRead = 1'b0; MemWrite = 4'b0000; req_valid = 1'b1;
    step();
    check("nop:ready", {31'd0, req_ready}, 32'd1);
    check("nop:en", {31'd0, mem_en}, 32'd0);
    idle_inputs();
    step();
    check("nop:valid", {31'd0, resp_valid}, 32'd0);

    // Reset while a load waits on the BRAM: the response is dropped.
    addr = 32'h200; MemRead = 1'b1; MemReadSize = 2'd2; req_valid = 1'b1;
    step();
    idle_inputs();
    step();
    check("rstw:in_wait_en", {31'd0, mem_en}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw:ready", {31'd0, req_ready}, 32'd1);
    check("rstw:valid", {31'd0, resp_valid}, 32'd0);
    step();
    check("rstw:valid2", {31'd0, resp_valid}, 32'd0);
    step();
    check("rstw:valid3", {31'd0, resp_valid}, 32'd0);

    // Reset while a store is being issued: no write strobe in the cycle after reset.
    addr = 32'h104; wdata = 32'h11111111; MemWrite = 4'b1111; req_valid = 1'b1;
    step();
    idle_inputs();
    check("rsts:issue_we", {28'd0, mem_we}, 32'h0000000F);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rsts:we", {28'd0, mem_we}, 32'd0);
    check("rsts:en", {31'd0, mem_en}, 32'd0);
    step();
    check("rsts:valid", {31'd0, resp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
